text_write_scheduler: RTL

TEXT_WRITE_SCHEDULER -- requirements
Module: text_write_scheduler

---
 rtl/text_pkg.sv | 14 +
 rtl/write_fifo.sv | 55 +++++
 rtl/text_write_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared types and constants for the text-mode write scheduler.
// Holds the FSM state encoding and the standard screen sizes.
package text_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FILL
  } state_t;

  localparam int TEXT_CELLS_1080 = 16080;
  localparam int TEXT_CELLS_480  = 2400;

endpackage

// File: rtl/write_fifo.sv
// Write queue for CPU character-cell writes.
// First-word-fall-through: rdata shows the head entry whenever empty is low.
module write_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/text_write_scheduler.sv
// Schedules CPU writes and screen fills into the character RAM,
// optionally restricted to vertical blank.
module text_write_scheduler
  import text_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TEXT_CELLS = TEXT_CELLS_1080,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             cpu_clk,
  input  logic             rst_p,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_data,
  input  logic             fill_start,
  input  logic [15:0]      fill_data,
  output logic             fill_busy,
  input  logic             vblank_async,
  input  logic             immediate,
  output logic             ram_we,
  output logic [15:0]      ram_addr,
  output logic [15:0]      ram_data,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam logic [15:0] LAST = 16'(TEXT_CELLS - 1);

  state_t      state;
  logic        vb_m;
  logic        vb_s;
  logic        gate;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic [15:0] fill_cnt;
  logic [15:0] fill_word;

  assign gate      = immediate | vb_s;
  assign req_ready = ~full;
  assign push      = req_valid & req_ready;

  write_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (cpu_clk),
    .rst   (rst_p),
    .push  (push),
    .pop   (pop),
    .wdata ({req_addr, req_data}),
    .rdata (head),
    .count (pending),
    .full  (full),
    .empty (empty)
  );

  // Bring vertical blank into the CPU clock domain.
  always_ff @(posedge cpu_clk) begin
    if (rst_p) begin
      vb_m <= 1'b0;
      vb_s <= 1'b0;
    end else begin
      vb_m <= vblank_async;
      vb_s <= vb_m;
    end
  end

  // Sticky record of any request refused because the queue was full.
  always_ff @(posedge cpu_clk) begin
    if (rst_p)                       overflow <= 1'b0;
    else if (req_valid & ~req_ready) overflow <= 1'b1;
  end

  // Pop the head when IDLE/DRAIN may write; a fill request wins in IDLE.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = ~fill_start & gate & ~empty;
      DRAIN:   pop = gate & ~empty;
      default: pop = 1'b0;
    endcase
  end

  // Main sequencer; the first pop is taken on the IDLE->DRAIN edge
  // so a queued write reaches the RAM two cycles after acceptance.
  always_ff @(posedge cpu_clk) begin
    if (rst_p) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      fill_word <= '0;
      fill_busy <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_start) begin
            state     <= FILL;
            fill_busy <= 1'b1;
            fill_word <= fill_data;
            fill_cnt  <= '0;
          end else if (pop) begin
            state    <= DRAIN;
            ram_we   <= 1'b1;
            ram_addr <= head[31:16];
            ram_data <= head[15:0];
          end
        end
        DRAIN: begin
          if (pop) begin
            ram_we   <= 1'b1;
            ram_addr <= head[31:16];
            ram_data <= head[15:0];
          end else begin
            state <= IDLE;
          end
        end
        FILL: begin
          if (gate) begin
            ram_we   <= 1'b1;
            ram_addr <= fill_cnt;
            ram_data <= fill_word;
            if (fill_cnt == LAST) begin
              state     <= IDLE;
              fill_busy <= 1'b0;
              fill_cnt  <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
